// File: rtl/lieat_ifu_ibuf_pkg.sv
// Shared fetch-buffer definitions: datapath widths, predecode opcodes, entry layout.
package lieat_ifu_ibuf_pkg;

  localparam int XLEN    = 32;
  localparam int BPU_IDX = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    inst;
    logic [BPU_IDX-1:0] index;
    logic               is_br;
  } ibuf_entry_t;

  function automatic logic predecode_is_br(input logic [XLEN-1:0] inst);
    return (inst[6:0] == OPC_BRANCH) || (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/lieat_ifu_ibuf_if.sv
// Fetch-response / decode handshake bundle around the instruction buffer.
interface lieat_ifu_ibuf_if #(parameter int PTR_W = 2);
  import lieat_ifu_ibuf_pkg::*;

  logic               flush_req;
  logic               if_o_valid;
  logic               ifetch_rsp_valid;
  logic [XLEN-1:0]    ifetch_rsp_pc;
  logic [BPU_IDX-1:0] ifetch_rsp_index;
  logic [XLEN-1:0]    ifetch_rsp_inst;
  logic               ibuf_o_ready;
  logic               id_o_valid;
  logic               id_o_ready;
  logic [XLEN-1:0]    id_o_pc;
  logic [XLEN-1:0]    id_o_inst;
  logic [BPU_IDX-1:0] id_o_index;
  logic               id_o_is_br;
  logic [PTR_W:0]     ibuf_cnt;
  logic               ibuf_ovf;

  // slave is the buffer itself; master is the surrounding fetch/decode side
  modport slave (
    input  flush_req, if_o_valid, ifetch_rsp_valid, ifetch_rsp_pc, ifetch_rsp_index,
           ifetch_rsp_inst, id_o_ready,
    output ibuf_o_ready, id_o_valid, id_o_pc, id_o_inst, id_o_index, id_o_is_br,
           ibuf_cnt, ibuf_ovf
  );

  modport master (
    output flush_req, if_o_valid, ifetch_rsp_valid, ifetch_rsp_pc, ifetch_rsp_index,
           ifetch_rsp_inst, id_o_ready,
    input  ibuf_o_ready, id_o_valid, id_o_pc, id_o_inst, id_o_index, id_o_is_br,
           ibuf_cnt, ibuf_ovf
  );

endinterface

// File: rtl/lieat_ifu_ibuf_ram.sv
// Payload store: one write port, asynchronous read of the head entry.
module lieat_ifu_ibuf_ram
  import lieat_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  ibuf_entry_t       wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output ibuf_entry_t       rdata_o
);

  ibuf_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lieat_ifu_ibuf.sv
// Instruction buffer between icache response and decode: circular FIFO with
// fetch-slot reservation and a sticky overflow flag.
module lieat_ifu_ibuf
  import lieat_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic             clk,
  input logic             rst,
  lieat_ifu_ibuf_if.slave ibuf_io
);

  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_EXT = (PTR_W+2)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             inflight_q, inflight_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, full, fetch_rdy;
  logic [PTR_W+1:0] occupancy;
  ibuf_entry_t      wr_entry, rd_entry;

  assign full               = (cnt_q == FULL_CNT);
  assign ibuf_io.id_o_valid = (cnt_q != '0) & ~ibuf_io.flush_req;
  assign pop                = ibuf_io.id_o_valid & ibuf_io.id_o_ready;
  assign push               = ibuf_io.ifetch_rsp_valid & ~ibuf_io.flush_req & (~full | pop);

  // An outstanding fetch holds a slot so its response can never be dropped.
  assign occupancy = {1'b0, cnt_q} + {{(PTR_W+1){1'b0}}, inflight_q};
  assign fetch_rdy = (occupancy < DEPTH_EXT);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    ovf_d      = ovf_q | (ibuf_io.ifetch_rsp_valid & ~ibuf_io.flush_req & full & ~pop);
    if (ibuf_io.flush_req) begin
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push & ~pop)      cnt_d = cnt_q + 1'b1;
      else if (pop & ~push) cnt_d = cnt_q - 1'b1;
      // A new request in the same cycle as a response keeps the reservation.
      if (ibuf_io.if_o_valid & fetch_rdy) inflight_d = 1'b1;
      else if (ibuf_io.ifetch_rsp_valid)  inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
    end
  end

  assign wr_entry.pc    = ibuf_io.ifetch_rsp_pc;
  assign wr_entry.inst  = ibuf_io.ifetch_rsp_inst;
  assign wr_entry.index = ibuf_io.ifetch_rsp_index;
  assign wr_entry.is_br = predecode_is_br(ibuf_io.ifetch_rsp_inst);

  lieat_ifu_ibuf_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (rd_entry)
  );

  assign ibuf_io.id_o_pc      = rd_entry.pc;
  assign ibuf_io.id_o_inst    = rd_entry.inst;
  assign ibuf_io.id_o_index   = rd_entry.index;
  assign ibuf_io.id_o_is_br   = rd_entry.is_br;
  assign ibuf_io.ibuf_o_ready = fetch_rdy;
  assign ibuf_io.ibuf_cnt     = cnt_q;
  assign ibuf_io.ibuf_ovf     = ovf_q;

endmodule

// File: doc/lieat_ifu_ibuf.md
LIEAT_IFU_IBUF -- requirements
Module: lieat_ifu_ibuf

Interface
REQ-001 Parameter DEPTH, default 4, number of buffer entries; SHALL be a power of two, at least 2.
REQ-002 Parameter PTR_W, default 2, pointer width, equal to log2(DEPTH).
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush_req  input  1  pipeline flush; discards all buffered and incoming instructions.
REQ-006 ifetch_rsp_valid  input  1  single-cycle pulse from the icache marking a returned instruction.
REQ-007 ifetch_rsp_pc  input  XLEN  PC of the returned instruction.
REQ-008 ifetch_rsp_index  input  BPU_IDX  BPU index of the returned instruction.
REQ-009 ifetch_rsp_inst  input  XLEN  instruction word.
REQ-010 ibuf_o_ready  output  1  asserted when a fetch may be issued; drives the icache if_o_ready.
REQ-011 id_o_valid  output  1  head entry is valid toward decode.
REQ-012 id_o_ready  input  1  decode accepts the head entry.
REQ-013 id_o_pc, id_o_inst  output  XLEN each  head entry PC and instruction.
REQ-014 id_o_index  output  BPU_IDX  head entry BPU index.
REQ-015 id_o_is_br  output  1  predecode flag: inst[6:0] is 1100011, 1101111 or 1100111.
REQ-016 ibuf_cnt  output  PTR_W+1  current occupancy.
REQ-017 ibuf_ovf  output  1  sticky overflow error flag.

Function
REQ-018 The block SHALL be a circular FIFO with head pointer, tail pointer and a PTR_W+1 bit count; pointers SHALL wrap modulo DEPTH.
REQ-019 Push SHALL occur when ifetch_rsp_valid & ~flush_req & (cnt<DEPTH | pop).
REQ-020 Pop SHALL occur when id_o_valid & id_o_ready.
REQ-021 Simultaneous push and pop SHALL leave cnt unchanged, including when cnt==DEPTH.
REQ-022 Latency SHALL be 1 cycle: an entry pushed at edge N SHALL drive id_o_valid in cycle N+1. There is no same-cycle bypass.
REQ-023 id_o_valid SHALL equal (cnt!=0) & ~flush_req, and id_o_* fields SHALL come from the head entry.
REQ-024 id_o_is_br SHALL be computed at push time and stored with the entry.
REQ-025 ibuf_o_ready SHALL equal (cnt + inflight) < DEPTH, where inflight is a 1-bit register. inflight SHALL set when the icache handshake (if_o_valid & ibuf_o_ready, with if_o_valid added as an input) occurs, and SHALL clear on ifetch_rsp_valid or flush_req. This reserves an entry for every outstanding fetch.
REQ-026 Input if_o_valid  input  1  icache fetch-request valid, used only for REQ-025.
REQ-027 flush_req SHALL zero head, tail, cnt and inflight at the next edge; a push or pop in the same cycle SHALL be discarded.
REQ-028 ifetch_rsp_valid while cnt==DEPTH with no pop SHALL drop the data, leave the FIFO unchanged, and set ibuf_ovf. ibuf_ovf SHALL clear only on reset.
REQ-029 Entry payload registers SHALL load only on push; no data reset is required.

Reset
REQ-030 On reset assertion, asynchronously: head=0, tail=0, cnt=0, inflight=0, ibuf_ovf=0.
REQ-031 Outputs SHALL be id_o_valid=0, ibuf_o_ready=1 and ibuf_cnt=0 while reset is high and in the first cycle after release.
REQ-032 Reset asserted mid-operation SHALL discard all entries with no output pulse.

Structure
REQ-033 The predecode opcodes (BRANCH, JAL, JALR) SHALL be constants in the shared defines header alongside XLEN and BPU_IDX.
REQ-034 Control state SHALL use the existing lieat_general_dffrd/dfflr cells.
REQ-035 The payload array SHALL be one sub-module, lieat_ifu_ibuf_ram (DEPTH x (2*XLEN+BPU_IDX+1), one write port, one asynchronous read port).

Verification
REQ-036 Scenario: after reset, push pc=0x80000000 inst=0x00000013 -> next cycle id_o_valid=1, id_o_pc=0x80000000, id_o_is_br=0, ibuf_cnt=1.
REQ-037 Scenario: four pushes with id_o_ready=0 -> ibuf_cnt=4, ibuf_o_ready=0; then a push plus pop in the same cycle -> ibuf_cnt stays 4 and order is preserved.
REQ-038 Scenario: fifth push while full with no pop -> data dropped, ibuf_ovf=1, and the flag stays set after later pops.
REQ-039 Scenario: push inst=0x0000006F (jal) -> id_o_is_br=1; inst=0x00008067 (jalr) -> id_o_is_br=1.
REQ-040 Scenario: flush_req with cnt=3 and a simultaneous push -> next cycle ibuf_cnt=0, id_o_valid=0, inflight=0.
REQ-041 Scenario: sustained push/pop for 20 cycles across pointer wrap -> output PC sequence exactly matches input sequence.
